// File: rtl/dense_layer_seq.sv
// rtl/dense_layer_seq.sv - fully-connected layer sequencer sharing one MAC across all neurons
// Optional feature macro: DENSE_SEQ_RELU_EN (clamp negative neuron results to zero)
module dense_layer_seq #(
   parameter int N_IN   = 4,
   parameter int N_OUT  = 2,
   parameter int DATA_W = 16,
   parameter int FRAC   = 8,
   parameter int ACC_W  = 40,
   localparam int WA_W  = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
   localparam int BA_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
   input  logic              ap_clk,
   input  logic              ap_rst,
   input  logic              ap_start,
   output logic              ap_done,
   output logic              ap_idle,
   output logic              ap_ready,
   input  logic [DATA_W-1:0] in_V,
   input  logic              in_V_ap_vld,
   output logic [WA_W-1:0]   w_addr,
   input  logic [DATA_W-1:0] w_data,
   output logic [BA_W-1:0]   b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic [DATA_W-1:0] out_V,
   output logic              out_V_ap_vld,
   output logic [BA_W-1:0]   out_idx
);

   localparam int I_W = $clog2(N_IN);
   localparam int K_W = $clog2(N_IN + 1);

   // Largest/smallest representable DATA_W values, widened to the accumulator
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [2:0] {IDLE, LOAD, MAC, OUT, DONE} state_t;

   state_t                   state, state_nxt;
   logic [I_W-1:0]           i;
   logic [K_W-1:0]           k;
   logic [BA_W-1:0]          j;
   logic signed [DATA_W-1:0] x [N_IN];
   logic signed [ACC_W-1:0]  acc;

   logic signed [DATA_W-1:0]   xsel;
   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    prod_ext;
   logic signed [ACC_W-1:0]    bias_ext;
   logic signed [ACC_W-1:0]    r;
   logic [DATA_W-1:0]          sat;
   logic [DATA_W-1:0]          res;

   // ROM data returned this cycle belongs to the address issued at k-1, so pair it with x[k-1]
   assign xsel     = x[I_W'(k - 1'b1)];
   assign prod     = xsel * $signed(w_data);
   assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
   assign bias_ext = {{(ACC_W-DATA_W-FRAC){b_data[DATA_W-1]}}, b_data, {FRAC{1'b0}}};

   // State register
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic, idle flag and ROM addressing
   always_comb begin
      state_nxt = state;
      ap_idle   = 1'b0;
      w_addr    = '0;
      b_addr    = '0;
      case (state)
         IDLE: begin
            ap_idle = 1'b1;
            if (ap_start) state_nxt = LOAD;
         end
         LOAD: if (in_V_ap_vld && i == I_W'(N_IN - 1)) state_nxt = MAC;
         MAC: begin
            if (k < K_W'(N_IN)) w_addr = WA_W'(int'(j) * N_IN + int'(k));
            if (k == '0)        b_addr = j;
            if (k == K_W'(N_IN)) state_nxt = OUT;
         end
         OUT:     state_nxt = (j == BA_W'(N_OUT - 1)) ? DONE : MAC;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Rescale the accumulator and clamp it into the output range
   always_comb begin
      r = acc >>> FRAC;
      if (r > SAT_MAX)      sat = {1'b0, {(DATA_W-1){1'b1}}};
      else if (r < SAT_MIN) sat = {1'b1, {(DATA_W-1){1'b0}}};
      else                  sat = r[DATA_W-1:0];
`ifdef DENSE_SEQ_RELU_EN
      res = sat[DATA_W-1] ? '0 : sat;
`else
      res = sat;
`endif
   end

   // Counters, input buffer, accumulator and registered outputs
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         i            <= '0;
         k            <= '0;
         j            <= '0;
         acc          <= '0;
         for (int n = 0; n < N_IN; n++) x[n] <= '0;
         out_V        <= '0;
         out_idx      <= '0;
         out_V_ap_vld <= 1'b0;
         ap_done      <= 1'b0;
         ap_ready     <= 1'b0;
      end else begin
         out_V_ap_vld <= 1'b0;
         ap_done      <= 1'b0;
         ap_ready     <= 1'b0;
         case (state)
            IDLE: begin
               i <= '0;
               k <= '0;
               j <= '0;
            end
            LOAD: begin
               k <= '0;
               j <= '0;
               if (in_V_ap_vld) begin
                  x[i] <= in_V;
                  i    <= i + 1'b1;
               end
            end
            MAC: begin
               // k=1 overwrites the accumulator, so nothing survives from the previous neuron
               if (k == K_W'(1))  acc <= bias_ext + prod_ext;
               else if (k != '0) acc <= acc + prod_ext;
               k <= (k == K_W'(N_IN)) ? '0 : k + 1'b1;
            end
            OUT: begin
               out_V        <= res;
               out_idx      <= j;
               out_V_ap_vld <= 1'b1;
               j            <= j + 1'b1;
            end
            DONE: begin
               ap_done  <= 1'b1;
               ap_ready <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dense_layer_seq.sv
// tb/tb_dense_layer_seq.sv - scoreboard bench for dense_layer_seq
module tb_dense_layer_seq;

   localparam int N_IN  = 4;
   localparam int N_OUT = 2;

   logic        ap_clk = 1'b0;
   logic        ap_rst;
   logic        ap_start;
   logic        ap_done, ap_idle, ap_ready;
   logic [15:0] in_V;
   logic        in_V_ap_vld;
   logic [2:0]  w_addr;
   logic [15:0] w_data;
   logic [0:0]  b_addr;
   logic [15:0] b_data;
   logic [15:0] out_V;
   logic        out_V_ap_vld;
   logic [0:0]  out_idx;

   logic signed [15:0] wm [N_IN*N_OUT];
   logic signed [15:0] bm [N_OUT];
   logic signed [15:0] xs [N_IN];

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [15:0] v;
      logic [0:0]  idx;
   } exp_t;
   exp_t sb[$];

   dense_layer_seq dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
      .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
      .in_V(in_V), .in_V_ap_vld(in_V_ap_vld),
      .w_addr(w_addr), .w_data(w_data), .b_addr(b_addr), .b_data(b_data),
      .out_V(out_V), .out_V_ap_vld(out_V_ap_vld), .out_idx(out_idx)
   );

   always #5 ap_clk = ~ap_clk;

   // 1-cycle-latency weight and bias ROMs
   always @(posedge ap_clk) begin
      w_data <= wm[w_addr];
      b_data <= bm[b_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] model(input int j);
      longint acc, r;
      acc = longint'(bm[j]) * 256;
      for (int k = 0; k < N_IN; k++) acc += longint'(xs[k]) * longint'(wm[j*N_IN+k]);
      r = acc >>> 8;
      if (r > 32767) r = 32767;
      else if (r < -32768) r = -32768;
`ifdef DENSE_SEQ_RELU_EN
      if (r < 0) r = 0;
`endif
      return r[15:0];
   endfunction

   task automatic push_model();
      for (int j = 0; j < N_OUT; j++) sb.push_back('{model(j), 1'(j)});
   endtask

   // Scoreboard consumer
   always @(negedge ap_clk) begin
      if (ap_rst === 1'b0 && out_V_ap_vld === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_strobe", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("out_V", out_V, e.v);
            check("out_idx", out_idx, e.idx);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation time limit");
   end

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic start_frame();
      ap_start = 1'b1;
      tick();
      ap_start = 1'b0;
   endtask

   task automatic feed(input logic [15:0] pat, input int len);
      int n;
      n = 0;
      for (int t = 0; t < len; t++) begin
         in_V_ap_vld = pat[t];
         in_V = pat[t] ? xs[n] : 16'hDEAD;
         tick();
         if (pat[t]) n++;
      end
      in_V_ap_vld = 1'b0;
      check("samples_fed", n, N_IN);
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (ap_done !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      check("done_seen", (n < 200), 1);
      check("ap_ready_with_done", ap_ready, 1);
   endtask

   task automatic set_uniform(input logic [15:0] xv, input logic [15:0] wv, input logic [15:0] bv);
      for (int k = 0; k < N_IN; k++) xs[k] = xv;
      for (int k = 0; k < N_IN*N_OUT; k++) wm[k] = wv;
      for (int k = 0; k < N_OUT; k++) bm[k] = bv;
   endtask

   task automatic set_mixed(input int seed);
      for (int k = 0; k < N_IN; k++) xs[k] = 16'(256 * (k + 1) - 512 * (k % 2) + seed);
      for (int k = 0; k < N_IN*N_OUT; k++) wm[k] = 16'(64 * k - 200 + 3 * seed);
      bm[0] = 16'(100 + seed);
      bm[1] = 16'(-300 - seed);
   endtask

   initial begin
      int n;
      ap_rst = 1'b1;
      ap_start = 1'b0;
      in_V = '0;
      in_V_ap_vld = 1'b0;
      set_uniform(16'd0, 16'd0, 16'd0);
      tick();
      tick();

      // Reset state
      check("rst_idle", ap_idle, 1);
      check("rst_done", ap_done, 0);
      check("rst_ready", ap_ready, 0);
      check("rst_out_V", out_V, 0);
      check("rst_out_vld", out_V_ap_vld, 0);
      check("rst_out_idx", out_idx, 0);
      check("rst_w_addr", w_addr, 0);
      check("rst_b_addr", b_addr, 0);
      ap_rst = 1'b0;
      tick();

      // Nominal: 1.0 * 0.5 * 4 + 0.25 = 2.25 -> 576
      set_uniform(16'd256, 16'd128, 16'd64);
      sb.push_back('{16'd576, 1'b0});
      sb.push_back('{16'd576, 1'b1});
      start_frame();
      feed(16'b1111, 4);
      wait_done(n);
      check("nominal_latency", n, 13);
      check("nominal_sb_empty", sb.size(), 0);
      tick();
      check("done_one_cycle", ap_done, 0);
      check("idle_after_done", ap_idle, 1);

      // Valid gaps 1,0,0,1,1,0,1: same results, done 3 cycles later from start
      sb.push_back('{16'd576, 1'b0});
      sb.push_back('{16'd576, 1'b1});
      start_frame();
      feed(16'b1011001, 7);
      wait_done(n);
      check("gaps_start_to_done", n + 7, 20);
      tick();

      // Gaps with distinct samples so capture order matters
      set_mixed(7);
      push_model();
      start_frame();
      feed(16'b1011001, 7);
      wait_done(n);
      check("gaps_order_latency", n, 13);
      tick();

      // Positive saturation
      set_uniform(16'd32767, 16'd32767, 16'd32767);
      sb.push_back('{16'd32767, 1'b0});
      sb.push_back('{16'd32767, 1'b1});
      start_frame();
      feed(16'b1111, 4);
      wait_done(n);
      tick();

      // Negative saturation (zero when the ReLU option is built in)
      set_uniform(16'd32767, 16'h8000, 16'd32767);
`ifdef DENSE_SEQ_RELU_EN
      sb.push_back('{16'd0, 1'b0});
      sb.push_back('{16'd0, 1'b1});
`else
      sb.push_back('{16'h8000, 1'b0});
      sb.push_back('{16'h8000, 1'b1});
`endif
      start_frame();
      feed(16'b1111, 4);
      wait_done(n);
      tick();

      // Busy start: pulse during MAC is ignored
      set_mixed(21);
      push_model();
      start_frame();
      feed(16'b1111, 4);
      tick();
      tick();
      ap_start = 1'b1;
      tick();
      ap_start = 1'b0;
      wait_done(n);
      check("busy_latency", n + 3, 13);
      for (int t = 0; t < 3; t++) begin
         tick();
         check("busy_stays_idle", ap_idle, 1);
      end

      // Reset at MAC k=2 of neuron 1
      set_uniform(16'd256, 16'd128, 16'd64);
      sb.push_back('{16'd576, 1'b0});
      sb.push_back('{16'd576, 1'b1});
      start_frame();
      feed(16'b1111, 4);
      for (int t = 0; t < 8; t++) tick();
      check("midrst_one_left", sb.size(), 1);
      ap_rst = 1'b1;
      #1;
      check("midrst_out_V", out_V, 0);
      check("midrst_out_vld", out_V_ap_vld, 0);
      check("midrst_idle", ap_idle, 1);
      check("midrst_w_addr", w_addr, 0);
      sb.delete();
      tick();
      ap_rst = 1'b0;
      tick();

      // Fresh frame after the abort: no stale accumulator
      set_mixed(-13);
      push_model();
      start_frame();
      feed(16'b1111, 4);
      wait_done(n);
      check("post_rst_latency", n, 13);
      tick();

      // Back-to-back with ap_start held high
      set_mixed(3);
      push_model();
      ap_start = 1'b1;
      tick();
      feed(16'b1111, 4);
      wait_done(n);
      check("b2b_idle_at_done", ap_idle, 1);
      set_mixed(40);
      push_model();
      tick();
      check("b2b_load_next_cycle", ap_idle, 0);
      ap_start = 1'b0;
      feed(16'b1111, 4);
      wait_done(n);
      check("b2b_second_latency", n, 13);
      tick();
      tick();

      check("final_sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dense_layer_seq.md
Name: dense_layer_seq

Overview:
- Sequencer for one fully-connected layer that time-shares a single multiply-accumulate unit across all N_OUT neurons.
- Accepts an ap_ctrl_hs start, captures N_IN input activations from a valid-qualified port, and reads weights and biases from external 1-cycle-latency ROMs.
- Emits one saturated fixed-point result per neuron with a valid strobe.
- Sits between the input stage and the layer output of the inference top level.

Parameters:
- N_IN, 4, inputs per neuron (≥2)
- N_OUT, 2, neurons per layer (≥1)
- DATA_W, 16, signed activation/weight/bias/output width
- FRAC, 8, fractional bits of all DATA_W values
- ACC_W, 40, signed accumulator width

Ports:
- ap_clk  in  1  clock, rising edge
- ap_rst  in  1  asynchronous active-high reset
- ap_start  in  1  start request
- ap_done  out  1  one-cycle completion pulse
- ap_idle  out  1  high in IDLE
- ap_ready  out  1  pulses with ap_done
- in_V  in  DATA_W  input activation
- in_V_ap_vld  in  1  in_V valid
- w_addr  out  clog2(N_IN*N_OUT)  weight ROM address
- w_data  in  DATA_W  weight, valid 1 cycle after w_addr
- b_addr  out  clog2(N_OUT) (min 1)  bias ROM address
- b_data  in  DATA_W  bias, valid 1 cycle after b_addr
- out_V  out  DATA_W  neuron result
- out_V_ap_vld  out  1  out_V valid strobe
- out_idx  out  clog2(N_OUT) (min 1)  neuron index of out_V

Behaviour:
- Reset (async, any state): FSM goes to IDLE; ap_idle=1; all other outputs, counters, accumulator and input buffer cleared to 0.
- FSM states: IDLE, LOAD, MAC, OUT, DONE.
- IDLE: when ap_start=1, go to LOAD next cycle with i=0. ap_start in any other state is ignored.
- LOAD: each cycle with in_V_ap_vld=1, store x[i]=in_V and increment i. The cycle storing x[N_IN-1] moves to MAC with j=0, k=0. Gaps in vld stall LOAD indefinitely.
- MAC: lasts N_IN+1 cycles per neuron, with k = 0..N_IN.
  - While k<N_IN: w_addr = j*N_IN+k.
  - At k=0: b_addr = j.
  - At k=1: acc = sext(b_data)<<FRAC + x[0]*w_data.
  - At k=2..N_IN: acc += x[k-1]*w_data.
  - After k=N_IN, go to OUT.
- OUT (1 cycle):
  - r = acc >>> FRAC (arithmetic).
  - out_V = r saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - out_idx = j; out_V_ap_vld = 1.
  - If j<N_OUT-1: j++ and return to MAC with k=0. Otherwise go to DONE.
- out_V and out_idx hold their values between strobes.
- DONE (1 cycle): ap_done = ap_ready = 1, then IDLE.
- Latency from last input capture to ap_done: N_OUT*(N_IN+2)+1 cycles.
- Products are full 2*DATA_W bits, sign-extended to ACC_W. No wrap is allowed within ACC_W at defaults.
- ap_start held high at DONE→IDLE starts a new frame on the following cycle.

Optional Feature:
- Macro: DENSE_SEQ_RELU_EN.
- Defined: in OUT, a negative saturated result outputs 0, and positive values pass unchanged.
- Undefined: signed results pass through unchanged.

Test Plan:
- Nominal: all x=256 (1.0), all w=128 (0.5), all b=64 (0.25), defaults → two strobes with out_V=576, out_idx=0 then 1. ap_done arrives 13 cycles after the last input.
- Saturation: x=32767, w=32767, b=32767 → out_V=32767. With x=32767, w=-32768 → out_V=-32768.
- ReLU: as the negative saturation case with DENSE_SEQ_RELU_EN defined → out_V=0. Without the macro → -32768.
- Valid gaps: in_V_ap_vld toggling 1,0,0,1,1,0,1 → exactly 4 samples captured in order. Results match the nominal case, with ap_done shifted by 3 cycles.
- Reset mid-operation: assert ap_rst at MAC k=2 of neuron 1 → outputs 0 and ap_idle=1 immediately. A later frame produces correct values with no stale accumulator.
- Busy start: pulse ap_start during MAC → ignored. Back-to-back: ap_start held continuously → second frame's LOAD begins 1 cycle after ap_done.
